// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller:
// forwarding select encoding and FSM state encoding.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle.
// HAZARD_PERF_CNT_EN adds the stall/flush performance counters.
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] ex_rd;
    logic       ex_load;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic       ex_branch_taken;
    logic       ex_jal;
    logic       ex_jalr;
    logic [4:0] mem_rd;
    logic       mem_regwrite;
    logic [4:0] wb_rd;
    logic       wb_regwrite;

    logic       pc_write_en;
    logic       if_id_write_en;
    logic       id_ex_stall;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       npc_redirect;
    logic [1:0] forward_a;
    logic [1:0] forward_b;

`ifdef HAZARD_PERF_CNT_EN
    parameter int XLEN = 32;
    logic [XLEN-1:0] stall_cycles;
    logic [XLEN-1:0] flush_events;
`endif

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_rd, ex_load, ex_rs1, ex_rs2,
        output ex_branch_taken, ex_jal, ex_jalr,
        output mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        input  pc_write_en, if_id_write_en, id_ex_stall,
        input  if_id_flush, id_ex_flush, npc_redirect,
`ifdef HAZARD_PERF_CNT_EN
        input  stall_cycles, flush_events,
`endif
        input  forward_a, forward_b
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_rd, ex_load, ex_rs1, ex_rs2,
        input  ex_branch_taken, ex_jal, ex_jalr,
        input  mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        output pc_write_en, if_id_write_en, id_ex_stall,
        output if_id_flush, id_ex_flush, npc_redirect,
`ifdef HAZARD_PERF_CNT_EN
        output stall_cycles, flush_events,
`endif
        output forward_a, forward_b
    );

endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// Combinational EX-stage operand forwarding selects.
// EX/MEM wins over MEM/WB; x0 never forwards.
module fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs1,
    input  logic [4:0] ex_rs2,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwrite,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwrite,
    output logic [1:0] forward_a,
    output logic [1:0] forward_b
);

    logic mem_ok;
    logic wb_ok;

    assign mem_ok = mem_regwrite && (mem_rd != 5'd0);
    assign wb_ok  = wb_regwrite && (wb_rd != 5'd0);

    always_comb begin
        forward_a = FWD_RF;
        if (mem_ok && mem_rd == ex_rs1)
            forward_a = FWD_MEM;
        else if (wb_ok && wb_rd == ex_rs1)
            forward_a = FWD_WB;
    end

    always_comb begin
        forward_b = FWD_RF;
        if (mem_ok && mem_rd == ex_rs2)
            forward_b = FWD_MEM;
        else if (wb_ok && wb_rd == ex_rs2)
            forward_b = FWD_WB;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall / redirect flush controller with forwarding selects.
// HAZARD_PERF_CNT_EN enables stall_cycles / flush_events counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int LOAD_USE_STALL_CYCLES = 1,
    parameter int XLEN                  = 32
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);

    if (LOAD_USE_STALL_CYCLES < 1 || LOAD_USE_STALL_CYCLES > 7
        || XLEN < 1) begin : g_bad_cfg
        $error("hazard_ctrl: illegal parameter value");
    end

    localparam logic [2:0] CNT_INIT = 3'(LOAD_USE_STALL_CYCLES - 1);

    state_t     state;
    logic [2:0] cnt;
    logic       hazard;
    logic       redirect;

    assign hazard = hz.ex_load && (hz.ex_rd != 5'd0) &&
                    ((hz.id_uses_rs1 && hz.id_rs1 == hz.ex_rd) ||
                     (hz.id_uses_rs2 && hz.id_rs2 == hz.ex_rd));

    assign redirect = hz.ex_branch_taken || hz.ex_jal || hz.ex_jalr;

    // The first stall cycle is issued from RUN, so STALL covers the rest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            unique case (state)
                RUN: begin
                    if (redirect) begin
                        state <= FLUSH;
                    end else if (hazard && LOAD_USE_STALL_CYCLES > 1) begin
                        state <= STALL;
                        cnt   <= CNT_INIT;
                    end
                end
                STALL: begin
                    if (cnt <= 3'd1) begin
                        state <= RUN;
                        cnt   <= 3'd0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                FLUSH: state <= RUN;
                default: begin
                    state <= RUN;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        hz.pc_write_en    = 1'b1;
        hz.if_id_write_en = 1'b1;
        hz.id_ex_stall    = 1'b0;
        hz.if_id_flush    = 1'b0;
        hz.id_ex_flush    = 1'b0;
        hz.npc_redirect   = 1'b0;
        unique case (state)
            RUN: begin
                if (redirect) begin
                    hz.npc_redirect = 1'b1;
                    hz.if_id_flush  = 1'b1;
                    hz.id_ex_flush  = 1'b1;
                end else if (hazard) begin
                    hz.pc_write_en    = 1'b0;
                    hz.if_id_write_en = 1'b0;
                    hz.id_ex_stall    = 1'b1;
                end
            end
            STALL: begin
                hz.pc_write_en    = 1'b0;
                hz.if_id_write_en = 1'b0;
                hz.id_ex_stall    = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hz.stall_cycles <= '0;
            hz.flush_events <= '0;
        end else begin
            if (hz.id_ex_stall)
                hz.stall_cycles <= hz.stall_cycles + 1'b1;
            if (state == RUN && redirect)
                hz.flush_events <= hz.flush_events + 1'b1;
        end
    end
`endif

    fwd_unit u_fwd (
        .ex_rs1       (hz.ex_rs1),
        .ex_rs2       (hz.ex_rs2),
        .mem_rd       (hz.mem_rd),
        .mem_regwrite (hz.mem_regwrite),
        .wb_rd        (hz.wb_rd),
        .wb_regwrite  (hz.wb_regwrite),
        .forward_a    (hz.forward_a),
        .forward_b    (hz.forward_b)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one DUT with 1 stall cycle,
// one with 3, both fed the same pipeline stimulus.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [4:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
    logic id_uses_rs1, id_uses_rs2, ex_load;
    logic ex_branch_taken, ex_jal, ex_jalr, mem_regwrite, wb_regwrite;

    int tests = 0;
    int fails = 0;

    // {pc_write_en, if_id_write_en, id_ex_stall, if_id_flush, id_ex_flush, npc_redirect}
    localparam logic [5:0] C_IDLE  = 6'b110000;
    localparam logic [5:0] C_STALL = 6'b001000;
    localparam logic [5:0] C_FLUSH = 6'b110111;

    hazard_ctrl_if ia ();
    hazard_ctrl_if ib ();

    hazard_ctrl #(.LOAD_USE_STALL_CYCLES(1)) u_a (.clk(clk), .rst(rst), .hz(ia));
    hazard_ctrl #(.LOAD_USE_STALL_CYCLES(3)) u_b (.clk(clk), .rst(rst), .hz(ib));

    always #5 clk = ~clk;

    assign ia.id_rs1 = id_rs1;           assign ib.id_rs1 = id_rs1;
    assign ia.id_rs2 = id_rs2;           assign ib.id_rs2 = id_rs2;
    assign ia.id_uses_rs1 = id_uses_rs1; assign ib.id_uses_rs1 = id_uses_rs1;
    assign ia.id_uses_rs2 = id_uses_rs2; assign ib.id_uses_rs2 = id_uses_rs2;
    assign ia.ex_rd = ex_rd;             assign ib.ex_rd = ex_rd;
    assign ia.ex_load = ex_load;         assign ib.ex_load = ex_load;
    assign ia.ex_rs1 = ex_rs1;           assign ib.ex_rs1 = ex_rs1;
    assign ia.ex_rs2 = ex_rs2;           assign ib.ex_rs2 = ex_rs2;
    assign ia.ex_branch_taken = ex_branch_taken;
    assign ib.ex_branch_taken = ex_branch_taken;
    assign ia.ex_jal = ex_jal;           assign ib.ex_jal = ex_jal;
    assign ia.ex_jalr = ex_jalr;         assign ib.ex_jalr = ex_jalr;
    assign ia.mem_rd = mem_rd;           assign ib.mem_rd = mem_rd;
    assign ia.mem_regwrite = mem_regwrite;
    assign ib.mem_regwrite = mem_regwrite;
    assign ia.wb_rd = wb_rd;             assign ib.wb_rd = wb_rd;
    assign ia.wb_regwrite = wb_regwrite; assign ib.wb_regwrite = wb_regwrite;

    wire [5:0] ctl_a = {ia.pc_write_en, ia.if_id_write_en, ia.id_ex_stall,
                        ia.if_id_flush, ia.id_ex_flush, ia.npc_redirect};
    wire [5:0] ctl_b = {ib.pc_write_en, ib.if_id_write_en, ib.id_ex_stall,
                        ib.if_id_flush, ib.id_ex_flush, ib.npc_redirect};

    task automatic clr();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rd = 5'd0; ex_load = 1'b0; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
        ex_branch_taken = 1'b0; ex_jal = 1'b0; ex_jalr = 1'b0;
        mem_rd = 5'd0; mem_regwrite = 1'b0; wb_rd = 5'd0; wb_regwrite = 1'b0;
    endtask

    // lw x5,0(x1) in EX, add x6,x5,x2 in ID
    task automatic set_load_use();
        ex_load = 1'b1; ex_rd = 5'd5;
        id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        id_rs2 = 5'd2; id_uses_rs2 = 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        clr();
        #1;
        tests++;
        if (ctl_a !== C_IDLE || ctl_b !== C_IDLE) begin
            fails++;
            $display("FAIL reset_ctl a=%b b=%b expected %b", ctl_a, ctl_b, C_IDLE);
        end
        tests++;
        if (ia.forward_a !== 2'b00 || ia.forward_b !== 2'b00) begin
            fails++;
            $display("FAIL reset_fwd got %b/%b expected 00/00", ia.forward_a, ia.forward_b);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_load_use();
        logic [5:0] exp_a [4];
        logic [5:0] exp_b [4];
        exp_a = '{C_STALL, C_IDLE, C_IDLE, C_IDLE};
        exp_b = '{C_STALL, C_STALL, C_STALL, C_IDLE};
        step();
        set_load_use();
        for (int i = 0; i < 4; i++) begin
            if (i == 1) clr();
            #1;
            tests++;
            if (ctl_a !== exp_a[i]) begin
                fails++;
                $display("FAIL load_use_n1 cyc%0d got %b expected %b", i, ctl_a, exp_a[i]);
            end
            tests++;
            if (ctl_b !== exp_b[i]) begin
                fails++;
                $display("FAIL load_use_n3 cyc%0d got %b expected %b", i, ctl_b, exp_b[i]);
            end
            step();
        end
    endtask

    task automatic test_rs2_hazard();
        clr();
        ex_load = 1'b1; ex_rd = 5'd9;
        id_rs2 = 5'd9; id_uses_rs2 = 1'b0;
        #1;
        tests++;
        if (ctl_a !== C_IDLE) begin
            fails++;
            $display("FAIL rs2_unused got %b expected %b", ctl_a, C_IDLE);
        end
        id_uses_rs2 = 1'b1;
        #1;
        tests++;
        if (ctl_a !== C_STALL) begin
            fails++;
            $display("FAIL rs2_hazard got %b expected %b", ctl_a, C_STALL);
        end
        clr();
        repeat (4) step();
    endtask

    task automatic test_jal();
        clr();
        ex_jal = 1'b1;
        #1;
        tests++;
        if (ctl_b !== C_FLUSH) begin
            fails++;
            $display("FAIL jal_flush got %b expected %b", ctl_b, C_FLUSH);
        end
        step();
        #1;
        tests++;
        if (ctl_b !== C_IDLE) begin
            fails++;
            $display("FAIL jal_flush_state got %b expected %b", ctl_b, C_IDLE);
        end
        clr();
        step();
        #1;
        tests++;
        if (ctl_b !== C_IDLE) begin
            fails++;
            $display("FAIL jal_back_run got %b expected %b", ctl_b, C_IDLE);
        end
        ex_jalr = 1'b1;
        #1;
        tests++;
        if (ctl_b !== C_FLUSH) begin
            fails++;
            $display("FAIL jalr_flush got %b expected %b", ctl_b, C_FLUSH);
        end
        step();
        clr();
        step();
    endtask

    task automatic test_branch_hazard();
        clr();
        set_load_use();
        ex_branch_taken = 1'b1;
        #1;
        tests++;
        if (ctl_b !== C_FLUSH) begin
            fails++;
            $display("FAIL branch_hazard got %b expected %b", ctl_b, C_FLUSH);
        end
        step();
        clr();
        #1;
        tests++;
        if (ctl_b !== C_IDLE) begin
            fails++;
            $display("FAIL branch_no_stall got %b expected %b", ctl_b, C_IDLE);
        end
        step();
        #1;
        tests++;
        if (ctl_b !== C_IDLE) begin
            fails++;
            $display("FAIL branch_after got %b expected %b", ctl_b, C_IDLE);
        end
    endtask

    task automatic test_forward();
        clr();
        ex_rs1 = 5'd7; ex_rs2 = 5'd7;
        mem_rd = 5'd7; mem_regwrite = 1'b1;
        wb_rd = 5'd7; wb_regwrite = 1'b1;
        #1;
        tests++;
        if (ia.forward_a !== 2'b10 || ia.forward_b !== 2'b10) begin
            fails++;
            $display("FAIL fwd_mem got %b/%b expected 10/10", ia.forward_a, ia.forward_b);
        end
        mem_rd = 5'd0;
        #1;
        tests++;
        if (ia.forward_a !== 2'b01 || ia.forward_b !== 2'b01) begin
            fails++;
            $display("FAIL fwd_wb got %b/%b expected 01/01", ia.forward_a, ia.forward_b);
        end
        ex_rs2 = 5'd3; mem_rd = 5'd3;
        #1;
        tests++;
        if (ia.forward_a !== 2'b01 || ia.forward_b !== 2'b10) begin
            fails++;
            $display("FAIL fwd_split got %b/%b expected 01/10", ia.forward_a, ia.forward_b);
        end
        mem_regwrite = 1'b0; wb_regwrite = 1'b0;
        #1;
        tests++;
        if (ia.forward_a !== 2'b00 || ia.forward_b !== 2'b00) begin
            fails++;
            $display("FAIL fwd_nowrite got %b/%b expected 00/00", ia.forward_a, ia.forward_b);
        end
        ex_rs1 = 5'd0; wb_rd = 5'd0; wb_regwrite = 1'b1;
        #1;
        tests++;
        if (ia.forward_a !== 2'b00) begin
            fails++;
            $display("FAIL fwd_x0 got %b expected 00", ia.forward_a);
        end
        clr();
    endtask

    task automatic test_x0();
        clr();
        ex_load = 1'b1; ex_rd = 5'd0;
        id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
        id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
        #1;
        tests++;
        if (ctl_a !== C_IDLE || ctl_b !== C_IDLE) begin
            fails++;
            $display("FAIL x0_no_stall a=%b b=%b expected %b", ctl_a, ctl_b, C_IDLE);
        end
        clr();
        step();
    endtask

    task automatic test_reset_mid_stall();
        clr();
        set_load_use();
        step();
        clr();
        #1;
        tests++;
        if (ctl_b !== C_STALL) begin
            fails++;
            $display("FAIL rst_pre_stall got %b expected %b", ctl_b, C_STALL);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (ctl_b !== C_IDLE) begin
            fails++;
            $display("FAIL rst_mid_stall got %b expected %b", ctl_b, C_IDLE);
        end
        step();
        rst = 1'b0;
        #1;
        tests++;
        if (ctl_b !== C_IDLE) begin
            fails++;
            $display("FAIL rst_release got %b expected %b", ctl_b, C_IDLE);
        end
        step();
        #1;
        tests++;
        if (ctl_b !== C_IDLE) begin
            fails++;
            $display("FAIL rst_run_normal got %b expected %b", ctl_b, C_IDLE);
        end
        set_load_use();
        step();
        clr();
        step();
        #1;
        tests++;
        if (ctl_b !== C_STALL) begin
            fails++;
            $display("FAIL rst_restall got %b expected %b", ctl_b, C_STALL);
        end
        step();
        #1;
        tests++;
        if (ctl_b !== C_IDLE) begin
            fails++;
            $display("FAIL rst_restall_end got %b expected %b", ctl_b, C_IDLE);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_rs2_hazard();
        test_jal();
        test_branch_hazard();
        test_forward();
        test_x0();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
